ibex_mem_arb: RTL

IBEX_MEM_ARB -- requirements
Module: ibex_mem_arb

---
 rtl/ibex_mem_arb_pkg.sv | 22 ++
 rtl/ibex_mem_arb_if.sv | 33 +++
 rtl/ibex_mem_arb_id_fifo.sv | 59 +++++
 rtl/ibex_mem_arb.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ibex_mem_arb_pkg.sv
// Shared types for the instr/data memory arbiter.
// Host IDs, FSM states and the round-robin pick helper.
package ibex_mem_arb_pkg;

  typedef enum logic {
    HostInstr = 1'b0,
    HostData  = 1'b1
  } host_id_e;

  typedef enum logic {
    ArbIdle = 1'b0,
    ArbHold = 1'b1
  } arb_state_e;

  // The host granted last time gets lowest priority.
  function automatic host_id_e rr_pick(
    host_id_e last
  );
    return (last == HostData) ? HostInstr : HostData;
  endfunction

endpackage

// File: rtl/ibex_mem_arb_if.sv
// One host-side memory bus (req/gnt + response).
// master: host side; slave: arbiter side.
interface ibex_mem_arb_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IntgWidth = 7
);
  logic                   req;
  logic                   gnt;
  logic [AddrWidth-1:0]   addr;
  logic                   we;
  logic [DataWidth/8-1:0] be;
  logic [DataWidth-1:0]   wdata;
  logic [IntgWidth-1:0]   wintg;
  logic                   rvalid;
  logic [DataWidth-1:0]   rdata;
  logic [IntgWidth-1:0]   rintg;
  logic                   err;

  modport master (
    output req, addr, we, be,
    output wdata, wintg,
    input  gnt, rvalid, rdata,
    input  rintg, err
  );

  modport slave (
    input  req, addr, we, be,
    input  wdata, wintg,
    output gnt, rvalid, rdata,
    output rintg, err
  );
endinterface

// File: rtl/ibex_mem_arb_id_fifo.sv
// In-order FIFO of granted host IDs awaiting response.
// Ports: push/push_id, pop, full, empty, head.
module ibex_mem_arb_id_fifo
  import ibex_mem_arb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  host_id_e push_id_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output host_id_e head_o
);

  localparam int unsigned PtrW =
    (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW =
    $clog2(Depth + 1);

  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  host_id_e        mem_q [Depth];

  function automatic logic [PtrW-1:0] inc(
    logic [PtrW-1:0] p
  );
    return (p == PtrW'(Depth - 1)) ?
      '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < Depth; i++)
        mem_q[i] <= HostInstr;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= push_id_i;
        wptr_q        <= inc(wptr_q);
      end
      if (pop_i)
        rptr_q <= inc(rptr_q);
      if (push_i && !pop_i)
        cnt_q <= cnt_q + CntW'(1);
      else if (pop_i && !push_i)
        cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/ibex_mem_arb.sv
// Arbitrates instr/data hosts onto one memory device.
// Hosts: instr_*/data_* req/gnt/addr/we/be/wdata/wintg,
// rvalid/rdata/rintg/err; device: dev_*; plus
// unexpected_rvalid_o. Define IBEX_MEM_ARB_RR_EN for
// round-robin; otherwise data has fixed priority.
module ibex_mem_arb
  import ibex_mem_arb_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IntgWidth      = 7,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   instr_req_i,
  output logic                   instr_gnt_o,
  input  logic [AddrWidth-1:0]   instr_addr_i,
  input  logic                   instr_we_i,
  input  logic [DataWidth/8-1:0] instr_be_i,
  input  logic [DataWidth-1:0]   instr_wdata_i,
  input  logic [IntgWidth-1:0]   instr_wintg_i,
  output logic                   instr_rvalid_o,
  output logic [DataWidth-1:0]   instr_rdata_o,
  output logic [IntgWidth-1:0]   instr_rintg_o,
  output logic                   instr_err_o,
  input  logic                   data_req_i,
  output logic                   data_gnt_o,
  input  logic [AddrWidth-1:0]   data_addr_i,
  input  logic                   data_we_i,
  input  logic [DataWidth/8-1:0] data_be_i,
  input  logic [DataWidth-1:0]   data_wdata_i,
  input  logic [IntgWidth-1:0]   data_wintg_i,
  output logic                   data_rvalid_o,
  output logic [DataWidth-1:0]   data_rdata_o,
  output logic [IntgWidth-1:0]   data_rintg_o,
  output logic                   data_err_o,
  output logic                   dev_req_o,
  input  logic                   dev_gnt_i,
  output logic [AddrWidth-1:0]   dev_addr_o,
  output logic                   dev_we_o,
  output logic [DataWidth/8-1:0] dev_be_o,
  output logic [DataWidth-1:0]   dev_wdata_o,
  output logic [IntgWidth-1:0]   dev_wintg_o,
  input  logic                   dev_rvalid_i,
  input  logic [DataWidth-1:0]   dev_rdata_i,
  input  logic [IntgWidth-1:0]   dev_rintg_i,
  input  logic                   dev_err_i,
  output logic                   unexpected_rvalid_o
);

  arb_state_e state_q;
  host_id_e   sel_q, pick, sel, fifo_head;
  logic       sel_req, dev_gnt, is_data;
  logic       fifo_full, fifo_empty, fifo_pop;
`ifdef IBEX_MEM_ARB_RR_EN
  host_id_e   last_q;
`endif

  always_comb begin
    pick = data_req_i ? HostData : HostInstr;
`ifdef IBEX_MEM_ARB_RR_EN
    if (instr_req_i && data_req_i)
      pick = rr_pick(last_q);
`endif
  end

  assign sel     = (state_q == ArbHold) ? sel_q : pick;
  assign is_data = (sel == HostData);
  assign sel_req = is_data ? data_req_i : instr_req_i;

  // Outputs are gated by rst_ni so nothing leaks while
  // reset is held, even with requests/rvalid asserted.
  assign dev_req_o   = rst_ni & sel_req & ~fifo_full;
  assign dev_gnt     = dev_req_o & dev_gnt_i;
  assign instr_gnt_o = dev_gnt & ~is_data;
  assign data_gnt_o  = dev_gnt & is_data;

  assign dev_addr_o  = is_data ? data_addr_i  : instr_addr_i;
  assign dev_we_o    = is_data ? data_we_i    : instr_we_i;
  assign dev_be_o    = is_data ? data_be_i    : instr_be_i;
  assign dev_wdata_o = is_data ? data_wdata_i : instr_wdata_i;
  assign dev_wintg_o = is_data ? data_wintg_i : instr_wintg_i;

  assign fifo_pop = rst_ni & dev_rvalid_i & ~fifo_empty;
  assign unexpected_rvalid_o =
    rst_ni & dev_rvalid_i & fifo_empty;

  assign instr_rvalid_o =
    fifo_pop & (fifo_head == HostInstr);
  assign data_rvalid_o  =
    fifo_pop & (fifo_head == HostData);
  assign instr_err_o    = instr_rvalid_o & dev_err_i;
  assign data_err_o     = data_rvalid_o & dev_err_i;
  assign instr_rdata_o  = dev_rdata_i;
  assign data_rdata_o   = dev_rdata_i;
  assign instr_rintg_o  = dev_rintg_i;
  assign data_rintg_o   = dev_rintg_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ArbIdle;
      sel_q   <= HostData;
`ifdef IBEX_MEM_ARB_RR_EN
      last_q  <= HostInstr;
`endif
    end else begin
      unique case (state_q)
        ArbIdle:
          if (dev_req_o && !dev_gnt_i) begin
            state_q <= ArbHold;
            sel_q   <= sel;
          end
        ArbHold:
          if (dev_gnt)
            state_q <= ArbIdle;
      endcase
`ifdef IBEX_MEM_ARB_RR_EN
      if (dev_gnt)
        last_q <= sel;
`endif
    end
  end

  ibex_mem_arb_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (dev_gnt),
    .push_id_i (sel),
    .pop_i     (fifo_pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (fifo_head)
  );

endmodule
